// File: rtl/tuart_rx_frame.sv
// Tiny-UART receiver: start/data/parity/stop framing, word-to-command assembly, error and idle-timeout flags.
// Build option: define TUART_RX_MAJORITY_EN to take every bit sample as a 2-of-3 vote over the last three RX levels.
module tuart_rx_frame #(
    parameter int CMD_WIDTH    = 32,
    parameter int DATA_BITS    = 8,
    parameter int SYS_CLK_F    = 100_000_000,
    parameter int BAUD_RATE    = 115_200,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_in,
    input  logic                 rx_sync_i,
    input  logic [1:0]           parity_mode_i,
    output logic [CMD_WIDTH-1:0] data_o,
    output logic                 rdy_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 timeout_o
);

    localparam int BIT_CLKS  = SYS_CLK_F / BAUD_RATE;
    localparam int HALF      = BIT_CLKS >> 1;
    localparam int CMD_WORDS = CMD_WIDTH / DATA_BITS;
    localparam int TO_LIMIT  = TIMEOUT_BITS * BIT_CLKS;
    localparam int TO_CMP    = (TO_LIMIT > 0) ? TO_LIMIT - 1 : 0;
    localparam int SCNT_W    = $clog2(BIT_CLKS);
    localparam int BIDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int WCNT_W    = (CMD_WORDS > 1) ? $clog2(CMD_WORDS) : 1;
    localparam int ICNT_W    = (TO_LIMIT > 0) ? $clog2(TO_LIMIT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 r_state, w_state_next;
    logic [SCNT_W-1:0]      r_samp_cnt, w_samp_cnt_next;
    logic [BIDX_W-1:0]      r_bit_idx, w_bit_idx_next;
    logic [DATA_BITS-1:0]   r_shift;
    logic [1:0]             r_par_mode;
    logic                   r_par_acc;
    logic                   r_done;
    logic                   r_stop_ok;
    logic                   r_par_ok;
    logic [CMD_WIDTH-1:0]   r_buf;
    logic [CMD_WIDTH-1:0]   w_buf_next;
    logic [WCNT_W-1:0]      r_word_cnt;
    logic [ICNT_W-1:0]      r_idle_cnt;

    logic w_sample;
    logic w_tick;
    logic w_half;
    logic w_par_en;
    logic w_last_word;
    logic w_start_det;
    logic w_take_data;
    logic w_take_par;
    logic w_take_stop;

`ifdef TUART_RX_MAJORITY_EN
    logic [1:0] r_hist;

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], rx_sync_i};
        end
    end

    assign w_sample = (rx_sync_i & r_hist[0]) | (rx_sync_i & r_hist[1]) | (r_hist[0] & r_hist[1]);
`else
    assign w_sample = rx_sync_i;
`endif

    assign w_tick      = (r_samp_cnt == SCNT_W'(BIT_CLKS - 1));
    assign w_half      = (r_samp_cnt == SCNT_W'(HALF - 1));
    assign w_par_en    = (r_par_mode == 2'b01) || (r_par_mode == 2'b10);
    assign w_last_word = (r_word_cnt == WCNT_W'(CMD_WORDS - 1));

    // Buffer image with the freshly received word dropped into slot r_word_cnt.
    for (genvar gi = 0; gi < CMD_WORDS; gi++) begin : g_slot
        assign w_buf_next[gi*DATA_BITS +: DATA_BITS] =
            (r_word_cnt == WCNT_W'(gi)) ? r_shift : r_buf[gi*DATA_BITS +: DATA_BITS];
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_state    <= S_IDLE;
            r_samp_cnt <= '0;
            r_bit_idx  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_samp_cnt <= w_samp_cnt_next;
            r_bit_idx  <= w_bit_idx_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_samp_cnt_next = r_samp_cnt + SCNT_W'(1);
        w_bit_idx_next  = r_bit_idx;
        w_start_det     = 1'b0;
        w_take_data     = 1'b0;
        w_take_par      = 1'b0;
        w_take_stop     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_samp_cnt_next = '0;
                if (!rx_sync_i) begin
                    w_start_det  = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_half) begin
                    w_samp_cnt_next = '0;
                    w_bit_idx_next  = '0;
                    // A high level at mid start bit is a false start.
                    w_state_next    = w_sample ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_samp_cnt_next = '0;
                    w_take_data     = 1'b1;
                    if (r_bit_idx == BIDX_W'(DATA_BITS - 1)) begin
                        w_state_next = w_par_en ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + BIDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_samp_cnt_next = '0;
                    w_take_par      = 1'b1;
                    w_state_next    = S_STOP;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_samp_cnt_next = '0;
                    w_take_stop     = 1'b1;
                    w_state_next    = w_sample ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                w_samp_cnt_next = '0;
                if (rx_sync_i) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_samp_cnt_next = '0;
                w_state_next    = S_IDLE;
            end
        endcase
    end

    // Bit assembly; the frame verdict is registered so commit happens one cycle after the stop sample.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_shift    <= '0;
            r_par_mode <= 2'b00;
            r_par_acc  <= 1'b0;
            r_done     <= 1'b0;
            r_stop_ok  <= 1'b0;
            r_par_ok   <= 1'b0;
        end else begin
            r_done <= w_take_stop;
            if (w_start_det) begin
                r_par_mode <= parity_mode_i;
                r_par_acc  <= 1'b0;
            end
            if (w_take_data) begin
                r_shift   <= {w_sample, r_shift[DATA_BITS-1:1]};
                r_par_acc <= r_par_acc ^ w_sample;
            end
            if (w_take_par) begin
                r_par_acc <= r_par_acc ^ w_sample;
            end
            if (w_take_stop) begin
                r_stop_ok <= w_sample;
                r_par_ok  <= !w_par_en || (r_par_mode[0] ? r_par_acc : !r_par_acc);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_buf        <= '0;
            r_word_cnt   <= '0;
            r_idle_cnt   <= '0;
            data_o       <= '0;
            rdy_o        <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            rdy_o        <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            timeout_o    <= 1'b0;

            if (r_done) begin
                if (!r_stop_ok) begin
                    frame_err_o <= 1'b1;
                    r_word_cnt  <= '0;
                end else if (!r_par_ok) begin
                    parity_err_o <= 1'b1;
                    r_word_cnt   <= '0;
                end else begin
                    r_buf <= w_buf_next;
                    if (w_last_word) begin
                        data_o     <= w_buf_next;
                        rdy_o      <= 1'b1;
                        r_word_cnt <= '0;
                    end else begin
                        r_word_cnt <= r_word_cnt + WCNT_W'(1);
                    end
                end
            end

            // Inter-word timeout: a start detected on the firing cycle takes priority.
            if (TO_LIMIT == 0 || w_start_det || r_word_cnt == '0) begin
                r_idle_cnt <= '0;
            end else if (r_state == S_IDLE) begin
                if (r_idle_cnt == ICNT_W'(TO_CMP)) begin
                    timeout_o  <= 1'b1;
                    r_word_cnt <= '0;
                    r_idle_cnt <= '0;
                end else begin
                    r_idle_cnt <= r_idle_cnt + ICNT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/tuart_rx_frame.md
# tuart_rx_frame

Parametrised Tiny-UART receiver with frame checking, the successor to the basic command receiver feeding the LogIP core. It receives UART frames with 1 start bit, variable data bits, optional runtime-selectable parity and 1 stop bit. It assembles CMD_WIDTH/DATA_BITS consecutive words into one command and flags false starts, parity errors, framing errors and inter-word timeouts. It sits between the RX synchroniser and the LogIP command decoder.

## Interface
- CMD_WIDTH, 32, command width in bits; must be a multiple of DATA_BITS.
- DATA_BITS, 8, data bits per frame, 5..9.
- SYS_CLK_F, 100_000_000, system clock in Hz.
- BAUD_RATE, 115_200, line rate; BIT_CLKS = SYS_CLK_F/BAUD_RATE (integer division), must be ≥ 4; HALF = BIT_CLKS>>1.
- TIMEOUT_BITS, 32, idle bit-times before a partial command is discarded; 0 disables the timeout.
- clk_i  input  1  system clock; all logic on the rising edge.
- rst_in  input  1  reset, asynchronous and active-low.
- rx_sync_i  input  1  already-synchronised RX line, idle high.
- parity_mode_i  input  2  00 none, 01 odd, 10 even, 11 treated as none; latched at start detection.
- data_o  output  CMD_WIDTH  last complete command; first received word in bits [DATA_BITS-1:0].
- rdy_o  output  1  one-cycle pulse, data_o valid.
- parity_err_o  output  1  one-cycle pulse.
- frame_err_o  output  1  one-cycle pulse.
- timeout_o  output  1  one-cycle pulse.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: if rx_sync_i=0 at cycle t, latch parity_mode_i, clear the sample counter and go to START.
- Start bit is sampled at t+HALF. If the sample is 1, this is a false start: return to IDLE with no flag.
- DATA: bit k (k=0..DATA_BITS-1, LSB first) is sampled at t+HALF+(k+1)·BIT_CLKS.
- PARITY is entered only when parity is enabled and is sampled one BIT_CLKS after the last data bit. The parity check covers the data bits plus the parity bit: odd mode requires an odd count of ones, even mode an even count.
- STOP is sampled one BIT_CLKS after the last data or parity bit. After STOP the FSM returns to IDLE on the next cycle.
- Valid frame (stop bit = 1, parity OK):
  - the word is written to slot word_cnt of the shift buffer;
  - if word_cnt = CMD_WORDS-1, data_o takes the buffer, rdy_o pulses and word_cnt clears;
  - otherwise word_cnt increments.
- Errors:
  - Stop bit = 0: frame_err_o pulses, word_cnt clears, state goes to BREAK. BREAK waits for rx_sync_i=1, then goes to IDLE.
  - Parity error with a good stop bit: parity_err_o pulses and word_cnt clears.
  - A bad stop bit takes precedence; only frame_err_o pulses.
  - After any error, data_o keeps its previous value.
- Timeout:
  - An idle counter runs in IDLE while word_cnt≠0 and clears on start detection.
  - When it reaches TIMEOUT_BITS·BIT_CLKS, timeout_o pulses and word_cnt clears.
  - With word_cnt=0 the counter is held at 0.
- Counter widths are $clog2(max+1); no counter wraps within a frame.

## Timing
- Reset (asynchronous, immediate): state=IDLE, all counters 0, buffer 0, data_o=0, rdy_o=0, parity_err_o=0, frame_err_o=0, timeout_o=0.
- Reset mid-frame discards the frame and any partial command.
- Outputs are registered. rdy_o, the error flags and the data_o update occur in the cycle after the STOP sample clock edge. Each flag is high for exactly 1 cycle.
- Start to rdy_o latency for the final word, counting clock edges from t: HALF + (DATA_BITS+P+1)·BIT_CLKS + 1, with P=1 if parity is enabled.
- A start edge arriving in the cycle right after the STOP sample is detected; back-to-back frames are supported.
- When a start is detected on the same cycle the timeout would fire, the start wins and no timeout is raised.

## Configuration
- TUART_RX_MAJORITY_EN defined:
  - a 3-bit history of rx_sync_i (current cycle and the previous 2) is kept;
  - each start, data, parity and stop sample is the 2-of-3 majority of that history;
  - a single-cycle glitch at a sample point is rejected.
- TUART_RX_MAJORITY_EN undefined: each sample is rx_sync_i at the sample cycle.
- Sample positions and latency are identical in both builds.

## Test plan
All scenarios use SYS_CLK_F=1_000_000, BAUD_RATE=100_000 (BIT_CLKS=10), CMD_WIDTH=32, DATA_BITS=8, TIMEOUT_BITS=32.
- No parity, frames 0x78,0x56,0x34,0x12 back-to-back → exactly one rdy_o pulse, data_o=0x12345678, no error flags.
- Even parity, frame 0xA5 with parity bit 1 → parity_err_o pulse, no rdy_o. Then 0x01,0x02,0x03,0x04 with correct parity → rdy_o, data_o=0x04030201.
- Frame 0x55 with stop bit 0, then line held low 50 cycles → frame_err_o pulse, no start detected while low. The next valid 4 frames give rdy_o with the correct data.
- RX low for 2 cycles in IDLE → false start, no flags, word_cnt unchanged. With TUART_RX_MAJORITY_EN, a 1-cycle inversion at a data-bit sample point → word still correct.
- Frames 0xAA,0xBB, then 320 idle cycles → timeout_o pulse at idle cycle 320. The next frames 0x11,0x22,0x33,0x44 give data_o=0x44332211.
- rst_in low in the middle of data bit 3 → all outputs 0 immediately. After release, 4 fresh frames give the correct command with no residual word.
